// File: rtl/iter_mul_unit_if.sv
// rtl/iter_mul_unit_if.sv - operand, control and result bundle for iter_mul_unit
//
// Purpose: groups the issue/result signals of the iterative multiplier so the
// controller (master) and the unit (slave) share one port.
// Signals:
//   start, flush             - issue a new operation / abort to idle
//   op_a, op_b               - multiplicand (Rn), multiplier (Rm)
//   acc_hi, acc_lo           - accumulate words (acc_hi used in long mode only)
//   is_signed, long_mode,
//   accumulate               - operation mode
//   busy, done               - operation in progress / one-cycle result strobe
//   result_lo, result_hi     - result words (result_hi is 0 in short mode)
//   flag_n, flag_z           - sign and zero of the selected result
interface iter_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             is_signed;
  logic             long_mode;
  logic             accumulate;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, flush, op_a, op_b, acc_hi, acc_lo, is_signed, long_mode, accumulate,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, flush, op_a, op_b, acc_hi, acc_lo, is_signed, long_mode, accumulate,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/iter_mul_unit.sv
// rtl/iter_mul_unit.sv - iterative radix-2 MUL/MLA/UMULL/SMULL/UMLAL/SMLAL unit
//
// Purpose: shift-and-add multiplier, one multiplier bit per cycle, followed by a
// single fix-up cycle that applies the sign and the accumulator.
// Ports:
//   i_clk   - rising-edge clock
//   i_reset - asynchronous active-low reset
//   bus     - iter_mul_unit_if.slave (operands, mode, start/flush, results, flags)
// Parameters:
//   WIDTH   - operand width; long results are 2*WIDTH bits
//   CNT_W   - iteration counter width; 2**CNT_W must exceed WIDTH
// Optional feature macro: MUL_EARLY_TERM_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are zero.
//   Result values are the same either way; only latency changes.
module iter_mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           i_clk,
  input  logic           i_reset,
  iter_mul_unit_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_neg;
  logic             r_long;
  logic             r_accum;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_flag_n;
  logic             r_flag_z;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_last;
  logic [PW-1:0]    w_signed_prod;
  logic [WIDTH-1:0] w_acc_hi_sel;
  logic [PW-1:0]    w_acc_ext;
  logic [PW-1:0]    w_final;

  // A new operation is only taken when the unit is free; flush wins over start.
  assign w_accept = bus.start && !bus.flush && (r_state == S_IDLE || r_state == S_DONE);

  // Magnitudes are formed modulo 2^WIDTH, so the most negative value maps to
  // 2^(WIDTH-1), which is its correct unsigned magnitude.
  assign w_a_neg = bus.is_signed && bus.op_a[WIDTH-1];
  assign w_b_neg = bus.is_signed && bus.op_b[WIDTH-1];
  assign w_abs_a = w_a_neg ? (WIDTH'(0) - bus.op_a) : bus.op_a;
  assign w_abs_b = w_b_neg ? (WIDTH'(0) - bus.op_b) : bus.op_b;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this step; the counter
  // still bounds the loop at WIDTH steps.
  assign w_last = (r_mplier[WIDTH-1:1] == '0) || (r_cnt == CNT_W'(WIDTH - 1));
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  // Fix-up: apply sign to the magnitude product, then add the accumulator.
  assign w_signed_prod = r_neg ? (PW'(0) - r_prod) : r_prod;
  assign w_acc_hi_sel  = r_long ? r_acc_hi : '0;
  assign w_acc_ext     = r_accum ? {w_acc_hi_sel, r_acc_lo} : '0;
  assign w_final       = w_signed_prod + w_acc_ext;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (bus.start) w_next = S_RUN;
        S_RUN:   if (w_last)    w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg    <= 1'b0;
      r_long   <= 1'b0;
      r_accum  <= 1'b0;
      r_cnt    <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_prod   <= '0;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_acc_hi <= bus.acc_hi;
      r_acc_lo <= bus.acc_lo;
      r_long   <= bus.long_mode;
      r_accum  <= bus.accumulate;
      r_cnt    <= '0;
    end else if (!bus.flush) begin
      if (r_state == S_RUN) begin
        if (r_mplier[0]) begin
          r_prod <= r_prod + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end else if (r_state == S_FIX) begin
        // Short mode keeps only the low word; signedness cannot affect it.
        r_res_lo <= w_final[WIDTH-1:0];
        r_res_hi <= r_long ? w_final[PW-1:WIDTH] : '0;
        r_flag_n <= r_long ? w_final[PW-1] : w_final[WIDTH-1];
        r_flag_z <= r_long ? (w_final == '0) : (w_final[WIDTH-1:0] == '0);
      end
    end
  end

  // busy/done decode the state register only, so outputs stay registered.
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result_lo = r_res_lo;
  assign bus.result_hi = r_res_hi;
  assign bus.flag_n    = r_flag_n;
  assign bus.flag_z    = r_flag_z;

endmodule

// File: tb/tb_iter_mul_unit.sv
// tb/tb_iter_mul_unit.sv - self-checking bench for iter_mul_unit
module tb_iter_mul_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iter_mul_unit_if #(.WIDTH(W)) bus();

  iter_mul_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a, b, ah, al;
    logic        sg, lg, acc;
    logic [31:0] eh, el;
    logic        en, ez;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full-precision signed/unsigned product plus accumulator, mod 2^64.
  function automatic logic [63:0] model_full(input logic [31:0] a, b, ah, al,
                                             input logic sg, lg, acc);
    longint pa, pb, p;
    if (sg) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'b0, a});
      pb = longint'({32'b0, b});
    end
    p = pa * pb;
    if (acc) p = p + (lg ? longint'({ah, al}) : longint'({32'b0, al}));
    return 64'(p);
  endfunction

  function automatic int exp_lat(input logic [31:0] b, input logic sg);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int it;
    m  = (sg && b[31]) ? (32'(0) - b) : b;
    it = 1;
    for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
    return it + 1;
`else
    return W + 1;
`endif
  endfunction

  // Called at a negedge. Issues an op, returns at the negedge where done is seen.
  // poke_e >= 0 re-asserts start (with different operands) for one cycle.
  task automatic run_op(input logic [31:0] a, b, ah, al, input logic sg, lg, acc,
                        input int poke_e, output int lat, output int bc, output bit ov);
    bus.op_a = a; bus.op_b = b; bus.acc_hi = ah; bus.acc_lo = al;
    bus.is_signed = sg; bus.long_mode = lg; bus.accumulate = acc;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; bc = 0; ov = 1'b0;
    for (int e = 0; e < 200; e++) begin
      if (e > 0) @(negedge clk);
      if (bus.busy && bus.done) ov = 1'b1;
      if (bus.done) begin
        lat = e;
        break;
      end
      if (bus.busy) bc++;
      if (e == poke_e) begin
        bus.start = 1'b1; bus.op_a = ~a; bus.op_b = ~b;
      end
      if (e == poke_e + 1) bus.start = 1'b0;
    end
  endtask

  task automatic do_op(input string nm, input logic [31:0] a, b, ah, al,
                       input logic sg, lg, acc,
                       input logic [31:0] eh, el, input logic en, ez, input int poke_e);
    int lat, bc;
    bit ov;
    run_op(a, b, ah, al, sg, lg, acc, poke_e, lat, bc, ov);
    check({nm, " latency"},   64'(lat), 64'(exp_lat(b, sg)));
    check({nm, " busy_cyc"},  64'(bc),  64'(exp_lat(b, sg)));
    check({nm, " busy&done"}, 64'(ov),  64'(0));
    check({nm, " hi"},        64'(bus.result_hi), 64'(eh));
    check({nm, " lo"},        64'(bus.result_lo), 64'(el));
    check({nm, " n"},         64'(bus.flag_n), 64'(en));
    check({nm, " z"},         64'(bus.flag_z), 64'(ez));
  endtask

  task automatic do_model_op(input string nm, input logic [31:0] a, b, ah, al,
                             input logic sg, lg, acc);
    logic [63:0] p;
    p = model_full(a, b, ah, al, sg, lg, acc);
    if (lg) do_op(nm, a, b, ah, al, sg, lg, acc, p[63:32], p[31:0], p[63], p == 64'd0, -1);
    else    do_op(nm, a, b, ah, al, sg, lg, acc, 32'd0, p[31:0], p[31], p[31:0] == 32'd0, -1);
  endtask

  initial begin
    // a, b, acc_hi, acc_lo, signed, long, acc, exp_hi, exp_lo, n, z
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 32'hFFFFFFFE, 32'h00000001, 1, 0};
    vecs[1] = '{32'hFFFFFFFE, 32'd3, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1, 0};
    vecs[2] = '{32'd7, 32'd6, 0, 32'd100, 0, 0, 1, 32'd0, 32'd142, 0, 0};
    vecs[3] = '{32'd0, 32'd5, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1};
    vecs[4] = '{32'd1, 32'd1, 32'h1, 32'hFFFFFFFF, 0, 1, 1, 32'h2, 32'h0, 0, 0};
    vecs[5] = '{32'h80000000, 32'h80000000, 0, 0, 1, 1, 0, 32'h40000000, 32'h0, 0, 0};
    vecs[6] = '{32'hFFFFFFFF, 32'd1, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0};
    vecs[7] = '{32'hFFFFFFFD, 32'd5, 0, 0, 1, 0, 0, 32'h0, 32'hFFFFFFF1, 1, 0};
    vecs[8] = '{32'hFFFFFFFF, 32'd1, 32'h0, 32'h1, 1, 1, 1, 32'h0, 32'h0, 0, 1};
    vecs[9] = '{32'h00010000, 32'h00010000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1};

    bus.start = 0; bus.flush = 0; bus.op_a = 0; bus.op_b = 0;
    bus.acc_hi = 0; bus.acc_lo = 0; bus.is_signed = 0; bus.long_mode = 0; bus.accumulate = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(bus.busy), 0);
    check("rst done", 64'(bus.done), 0);
    check("rst lo",   64'(bus.result_lo), 0);
    check("rst hi",   64'(bus.result_hi), 0);
    check("rst n",    64'(bus.flag_n), 0);
    check("rst z",    64'(bus.flag_z), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ah, vecs[i].al,
            vecs[i].sg, vecs[i].lg, vecs[i].acc, vecs[i].eh, vecs[i].el,
            vecs[i].en, vecs[i].ez, -1);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), 64'(bus.done), 0);
      check($sformatf("vec%0d idle_busy", i), 64'(bus.busy), 0);
    end

    // Second start during RUN is ignored.
    do_op("ign_start", 32'd3, 32'd5, 0, 0, 0, 1, 0, 32'd0, 32'd15, 0, 0, 4);
    @(negedge clk);
    check("ign_start no_requeue", 64'(bus.busy), 0);

    // Flush mid-RUN: no done, previous results (0:15) held.
    begin
      bit saw_done;
      bus.op_a = 32'd9; bus.op_b = 32'd9; bus.long_mode = 1; bus.is_signed = 0;
      bus.accumulate = 0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush busy", 64'(bus.busy), 0);
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (bus.done) saw_done = 1'b1;
        @(negedge clk);
      end
      check("flush no_done", 64'(saw_done), 0);
      check("flush hold_lo", 64'(bus.result_lo), 64'd15);
      check("flush hold_hi", 64'(bus.result_hi), 64'd0);
      check("flush hold_z",  64'(bus.flag_z), 0);
    end

    // Back-to-back: start held while in DONE.
    do_op("b2b_first",  32'd11, 32'd13, 0, 0, 0, 0, 0, 32'd0, 32'd143, 0, 0, -1);
    do_op("b2b_second", 32'd20, 32'd30, 0, 0, 0, 1, 0, 32'd0, 32'd600, 0, 0, -1);
    @(negedge clk);
    check("b2b done_pulse", 64'(bus.done), 0);

    // Asynchronous reset mid-RUN.
    bus.op_a = 32'd5; bus.op_b = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", 64'(bus.busy), 0);
    check("arst done", 64'(bus.done), 0);
    check("arst lo",   64'(bus.result_lo), 0);
    check("arst hi",   64'(bus.result_hi), 0);
    check("arst n",    64'(bus.flag_n), 0);
    check("arst z",    64'(bus.flag_z), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 32'd5, 32'd7, 0, 0, 0, 1, 0, 32'd0, 32'd35, 0, 0, -1);
    @(negedge clk);
    do_op("b_one", 32'd123, 32'd1, 0, 0, 0, 0, 0, 32'd0, 32'd123, 0, 0, -1);
    @(negedge clk);

    // Randomised operations against the reference model.
    for (int r = 0; r < 30; r++) begin
      logic [31:0] ra, rb, rh, rl;
      logic rs, rlg, rac;
      ra  = $urandom;
      rb  = $urandom;
      if (r % 3 == 1) rb = rb & 32'h0000_00FF;
      rh  = $urandom;
      rl  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      rlg = 1'($urandom_range(0, 1));
      rac = 1'($urandom_range(0, 1));
      do_model_op($sformatf("rnd%0d", r), ra, rb, rh, rl, rs, rlg, rac);
      if (r % 2 == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_mul_unit.md
# iter_mul_unit

Iterative multi-cycle multiply / multiply-accumulate unit for the multi-cycle ARM core. It replaces the single-cycle combinational multiply path in the ALU. It covers MUL, MLA, UMULL, SMULL, UMLAL and SMLAL at a parametrised operand width. The controller starts an operation, holds in a wait state while `busy` is high, and writes back `result_lo` to Rd and `result_hi` to Ra when `done` pulses.

## Interface
- `WIDTH`, default 32: operand width; the long product is 2*WIDTH bits.
- `CNT_W`, default 6: iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a new operation.
- `flush`, in, 1: synchronous abort to IDLE.
- `op_a`, in, WIDTH: multiplicand (Rn).
- `op_b`, in, WIDTH: multiplier (Rm).
- `acc_hi`, in, WIDTH: accumulate high word (long modes only).
- `acc_lo`, in, WIDTH: accumulate low word.
- `is_signed`, in, 1: two's-complement operands.
- `long_mode`, in, 1: produce a 2*WIDTH result.
- `accumulate`, in, 1: add the accumulator.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse; results valid.
- `result_lo`, out, WIDTH: low result word.
- `result_hi`, out, WIDTH: high result word; 0 when `long_mode`=0.
- `flag_n`, out, 1: sign of the selected result.
- `flag_z`, out, 1: selected result is zero.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE or DONE, `start`=1:
  - Latch all operand and mode inputs.
  - Store |a| and |b| when `is_signed`=1; raw values otherwise.
  - Store neg = a[MSB] XOR b[MSB] when `is_signed`=1; neg = 0 otherwise.
  - Clear the 2*WIDTH product accumulator.
  - Go to RUN.
- RUN, one radix-2 step per cycle:
  - If the multiplier LSB = 1, add the multiplicand to the product.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Go to FIX after WIDTH steps (see Configuration).
- FIX:
  - If neg = 1, product = two's-complement negation of the product.
  - If `accumulate`=1, add {acc_hi, acc_lo} when long, or {0, acc_lo} when short.
  - All arithmetic is modulo 2^(2*WIDTH).
  - Register the results and go to DONE.
- Short mode result: `result_lo` = product[WIDTH-1:0]; `result_hi` = 0. Signedness has no effect on the low word.
- Long mode result: `result_hi`/`result_lo` = product[2W-1:W] and product[W-1:0].
- Flags:
  - `flag_n` = `result_hi` MSB when long, `result_lo` MSB when short.
  - `flag_z` = 1 when the selected full result (2W bits long, W bits short) is all zero.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. If `start`=1 in DONE, go directly to RUN.
- `start` in RUN or FIX is ignored: no queuing and no effect on the operation in flight.
- `flush`:
  - Any state goes to IDLE on the next edge with no `done`.
  - `result_*` and flags hold their previous values.
  - `flush` takes priority over `start` in the same cycle.
- Results and flags hold from DONE until the next FIX completes.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = IDLE.
  - `busy`=0, `done`=0.
  - `result_lo`=`result_hi`=0, `flag_n`=0, `flag_z`=0.
  - Internal registers cleared.
  - Reset mid-operation discards the operation; no `done` is produced.
- Let edge k accept `start`:
  - `busy`=1 from after edge k until edge k+WIDTH+1.
  - Edges k+1..k+WIDTH perform the iterations.
  - Edge k+WIDTH+1 performs FIX and enters DONE.
  - `done`=1 and results are valid in the cycle after edge k+WIDTH+1.
- Latency: start to done = WIDTH+1 edges (33 for WIDTH=32). Back-to-back issue interval = WIDTH+2 cycles.
- `busy`=0 in IDLE and DONE. `busy` and `done` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - RUN exits to FIX once the remaining multiplier register is zero after the current step.
  - Iteration count = max(1, index of the highest set bit of the stored multiplier + 1).
  - Latency = iterations + 1 edges; minimum 2 (|b| = 0 or 1).
- `MUL_EARLY_TERM_EN` undefined: always WIDTH iterations and fixed latency.
- Result values are identical in both builds.

## Test plan
- UMULL, WIDTH=32, a=b=0xFFFFFFFF -> `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, `flag_n`=1, `flag_z`=0. `done` 33 edges after start (non-early-term build); `busy` high for exactly 33 cycles.
- SMULL, a=0xFFFFFFFE (-2), b=3 -> `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFFA, `flag_n`=1.
- MLA short, a=7, b=6, acc_lo=100 -> `result_lo`=142, `result_hi`=0, `flag_z`=0. Then MUL a=0, b=5 -> `result_lo`=0, `flag_z`=1.
- UMLAL, a=1, b=1, {acc_hi, acc_lo}={0x00000001, 0xFFFFFFFF} -> `result_hi`=0x00000002, `result_lo`=0x00000000, `flag_z`=0.
- Control:
  - Second `start` at edge k+5 is ignored; result unchanged, `done` still at k+33.
  - `flush` at k+10 -> `busy`=0 after edge k+11, no `done`, previous results held.
  - `start` held during DONE -> new operation runs with no IDLE gap.
- `reset` driven low mid-RUN (between edges) -> all outputs 0 immediately; `start` after release -> correct result with full latency. With `MUL_EARLY_TERM_EN`, b=1 -> `done` 2 edges after start.
